// File: rtl/clk_rst_seq_if.sv
// rtl/clk_rst_seq_if.sv - control/status bundle between a system controller and clk_rst_seq
interface clk_rst_seq_if #(
  parameter int NUM_DOM = 5
);
  logic [NUM_DOM-1:0] pll_locked_i;
  logic [NUM_DOM-1:0] dom_en_i;
  logic [NUM_DOM-1:0] dom_srst_req_i;
  logic               lock_lost_clr_i;
  logic [NUM_DOM-1:0] clk_en_o;
  logic [NUM_DOM-1:0] rst_o;
  logic [NUM_DOM-1:0] dom_ready_o;
  logic [NUM_DOM-1:0] lock_lost_o;
  logic               seq_busy_o;

  modport master (
    output pll_locked_i, dom_en_i, dom_srst_req_i, lock_lost_clr_i,
    input  clk_en_o, rst_o, dom_ready_o, lock_lost_o, seq_busy_o
  );

  modport slave (
    input  pll_locked_i, dom_en_i, dom_srst_req_i, lock_lost_clr_i,
    output clk_en_o, rst_o, dom_ready_o, lock_lost_o, seq_busy_o
  );
endinterface

// File: rtl/clk_rst_seq.sv
// rtl/clk_rst_seq.sv - multi-domain clock-enable and reset sequencer with ordered, gapped release
module clk_rst_seq #(
  parameter int NUM_DOM     = 5,
  parameter int LOCK_STABLE = 64,
  parameter int CLK_SETTLE  = 8,
  parameter int RST_GAP     = 16
) (
  input  logic         ref_clk_i,
  input  logic         glob_srst_i,
  clk_rst_seq_if.slave bus
);
  localparam int MAX_A = (LOCK_STABLE > CLK_SETTLE) ? LOCK_STABLE : CLK_SETTLE;
  localparam int MAX_B = (MAX_A > RST_GAP + 1) ? MAX_A : RST_GAP + 1;
  localparam int CNT_W = $clog2(MAX_B + 1);

  typedef enum logic [2:0] {
    S_OFF, S_LOCKWAIT, S_SETTLE, S_PENDING, S_RUN, S_DRAIN
  } state_t;

  state_t             r_state   [NUM_DOM];
  state_t             w_state_nxt [NUM_DOM];
  logic [CNT_W-1:0]   r_cnt     [NUM_DOM];
  logic [CNT_W-1:0]   w_cnt_nxt [NUM_DOM];
  logic [CNT_W-1:0]   r_gap;
  logic [CNT_W-1:0]   w_gap_nxt;
  logic [NUM_DOM-1:0] r_clk_en, r_rst, r_ready, r_lock_lost;
  logic               r_busy;
  logic [NUM_DOM-1:0] w_clk_en_nxt, w_rst_nxt, w_ready_nxt, w_ll_nxt, w_ll_set, w_gnt;
  logic               w_busy_nxt, w_found, w_load;

  always_comb begin
    w_gnt   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_DOM; i++) begin
      if (!w_found && r_state[i] == S_PENDING) begin
        w_found  = 1'b1;
        w_gnt[i] = (r_gap == '0);
      end
    end

    w_load   = 1'b0;
    w_ll_set = '0;
    for (int i = 0; i < NUM_DOM; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      if ((r_state[i] inside {S_SETTLE, S_PENDING, S_RUN, S_DRAIN}) && !bus.pll_locked_i[i]) begin
        w_state_nxt[i] = bus.dom_en_i[i] ? S_LOCKWAIT : S_OFF;
        w_cnt_nxt[i]   = '0;
        w_ll_set[i]    = 1'b1;
      end else if (!bus.dom_en_i[i] && (r_state[i] inside {S_SETTLE, S_PENDING, S_RUN})) begin
        w_state_nxt[i] = S_DRAIN;
        w_cnt_nxt[i]   = '0;
      end else if (!bus.dom_en_i[i] && r_state[i] == S_LOCKWAIT) begin
        w_state_nxt[i] = S_OFF;
        w_cnt_nxt[i]   = '0;
      end else begin
        case (r_state[i])
          S_OFF: begin
            w_state_nxt[i] = S_LOCKWAIT;
            w_cnt_nxt[i]   = '0;
          end
          S_LOCKWAIT: begin
            if (!bus.pll_locked_i[i]) begin
              w_cnt_nxt[i] = '0;
            end else if (r_cnt[i] == CNT_W'(LOCK_STABLE - 1)) begin
              w_state_nxt[i] = S_SETTLE;
              w_cnt_nxt[i]   = '0;
            end else begin
              w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
          end
          S_SETTLE: begin
            if (r_cnt[i] == CNT_W'(CLK_SETTLE - 1)) begin
              w_state_nxt[i] = S_PENDING;
              w_cnt_nxt[i]   = '0;
            end else begin
              w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
          end
          S_PENDING: begin
            // a cancelled grant never reaches here, so the gap is only loaded on a real release
            if (w_gnt[i]) begin
              w_state_nxt[i] = S_RUN;
              w_load         = 1'b1;
            end
          end
          S_RUN: begin
            if (bus.dom_srst_req_i[i]) begin
              w_state_nxt[i] = S_SETTLE;
              w_cnt_nxt[i]   = '0;
            end
          end
          S_DRAIN: begin
            if (r_cnt[i] == CNT_W'(CLK_SETTLE - 1)) begin
              w_state_nxt[i] = S_OFF;
              w_cnt_nxt[i]   = '0;
            end else begin
              w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
          end
          default: begin
            w_state_nxt[i] = S_OFF;
            w_cnt_nxt[i]   = '0;
          end
        endcase
        if (r_state[i] == S_OFF && !bus.dom_en_i[i]) begin
          w_state_nxt[i] = S_OFF;
        end
      end
    end

    if (w_load) begin
      w_gap_nxt = CNT_W'(RST_GAP);
    end else if (r_gap != '0) begin
      w_gap_nxt = r_gap - CNT_W'(1);
    end else begin
      w_gap_nxt = r_gap;
    end

    w_busy_nxt = 1'b0;
    for (int i = 0; i < NUM_DOM; i++) begin
      w_clk_en_nxt[i] = w_state_nxt[i] inside {S_SETTLE, S_PENDING, S_RUN, S_DRAIN};
      w_rst_nxt[i]    = (w_state_nxt[i] != S_RUN);
      w_ready_nxt[i]  = (w_state_nxt[i] == S_RUN);
      w_busy_nxt      = w_busy_nxt | (w_state_nxt[i] inside {S_LOCKWAIT, S_SETTLE, S_PENDING, S_DRAIN});
    end
    // a new lock-loss event wins over a simultaneous clear
    w_ll_nxt = (r_lock_lost & ~{NUM_DOM{bus.lock_lost_clr_i}}) | w_ll_set;
  end

  always_ff @(posedge ref_clk_i) begin
    if (glob_srst_i) begin
      for (int i = 0; i < NUM_DOM; i++) begin
        r_state[i] <= S_OFF;
        r_cnt[i]   <= '0;
      end
      r_gap       <= '0;
      r_clk_en    <= '0;
      r_rst       <= '1;
      r_ready     <= '0;
      r_lock_lost <= '0;
      r_busy      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DOM; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      r_gap       <= w_gap_nxt;
      r_clk_en    <= w_clk_en_nxt;
      r_rst       <= w_rst_nxt;
      r_ready     <= w_ready_nxt;
      r_lock_lost <= w_ll_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign bus.clk_en_o    = r_clk_en;
  assign bus.rst_o       = r_rst;
  assign bus.dom_ready_o = r_ready;
  assign bus.lock_lost_o = r_lock_lost;
  assign bus.seq_busy_o  = r_busy;
endmodule
